// File: rtl/uart_tx_frame_serializer.sv
// UART transmit frame serializer.
// Takes one parallel word through a valid/ready handshake and shifts it out
// as start bit, data bits LSB first, an optional parity bit and stop bits.
// Each bit lasts max(prescale,1) clock cycles, timed by an internal counter.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int STOP_BITS      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_valid,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_ready,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      serial_out,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  txState_t                  r_state;
  logic [PRESCALE_WIDTH-1:0] r_baudCnt;
  logic [PRESCALE_WIDTH-1:0] r_baudMax;
  logic [IDX_W-1:0]          r_bitIdx;
  logic                      r_stopCnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_parEn;
  logic                      r_parBit;
  logic                      r_serialOut;
  logic                      r_txDone;

  txState_t                  w_nextState;
  logic [PRESCALE_WIDTH-1:0] w_nextBaud;
  logic [IDX_W-1:0]          w_nextIdx;
  logic                      w_nextStop;
  logic [DATA_WIDTH-1:0]     w_nextShift;
  logic                      w_nextSerial;
  logic                      w_nextDone;
  logic                      w_accept;
  logic                      w_baudLast;
  logic [PRESCALE_WIDTH-1:0] w_prescaleMax;

  // A prescale of zero behaves like one, so the terminal count is clamped at zero.
  assign w_prescaleMax = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
  assign w_baudLast    = (r_baudCnt == r_baudMax);
  assign w_accept      = (r_state == IDLE) && tx_valid;

  assign tx_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign serial_out = r_serialOut;
  assign tx_done    = r_txDone;

  // State, counters and the registered line level advance together each clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_baudCnt   <= '0;
      r_bitIdx    <= '0;
      r_stopCnt   <= 1'b0;
      r_shift     <= '0;
      r_serialOut <= 1'b1;
      r_txDone    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_baudCnt   <= w_nextBaud;
      r_bitIdx    <= w_nextIdx;
      r_stopCnt   <= w_nextStop;
      r_shift     <= w_nextShift;
      r_serialOut <= w_nextSerial;
      r_txDone    <= w_nextDone;
    end
  end

  // Frame options are captured at acceptance so mid-frame input changes are harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baudMax <= '0;
      r_parEn   <= 1'b0;
      r_parBit  <= 1'b0;
    end else if (w_accept) begin
      r_baudMax <= w_prescaleMax;
      r_parEn   <= parity_enable;
      r_parBit  <= parity_type ? ~^tx_data : ^tx_data;
    end
  end

  // Next-state logic also decides the level the line takes after this edge.
  always_comb begin
    w_nextState  = r_state;
    w_nextBaud   = r_baudCnt;
    w_nextIdx    = r_bitIdx;
    w_nextStop   = r_stopCnt;
    w_nextShift  = r_shift;
    w_nextSerial = 1'b1;
    w_nextDone   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState  = START;
          w_nextBaud   = '0;
          w_nextShift  = tx_data;
          w_nextSerial = 1'b0;
        end
      end
      START: begin
        w_nextSerial = 1'b0;
        if (w_baudLast) begin
          w_nextState  = DATA;
          w_nextBaud   = '0;
          w_nextIdx    = '0;
          w_nextSerial = r_shift[0];
        end else begin
          w_nextBaud = r_baudCnt + PRESCALE_WIDTH'(1);
        end
      end
      DATA: begin
        w_nextSerial = r_shift[0];
        if (w_baudLast) begin
          w_nextBaud = '0;
          if (r_bitIdx == LAST_IDX) begin
            if (r_parEn) begin
              w_nextState  = PARITY;
              w_nextSerial = r_parBit;
            end else begin
              w_nextState  = STOP;
              w_nextStop   = 1'b0;
              w_nextSerial = 1'b1;
            end
          end else begin
            w_nextIdx    = r_bitIdx + IDX_W'(1);
            w_nextShift  = r_shift >> 1;
            w_nextSerial = r_shift[1];
          end
        end else begin
          w_nextBaud = r_baudCnt + PRESCALE_WIDTH'(1);
        end
      end
      PARITY: begin
        w_nextSerial = r_parBit;
        if (w_baudLast) begin
          w_nextState  = STOP;
          w_nextBaud   = '0;
          w_nextStop   = 1'b0;
          w_nextSerial = 1'b1;
        end else begin
          w_nextBaud = r_baudCnt + PRESCALE_WIDTH'(1);
        end
      end
      STOP: begin
        w_nextSerial = 1'b1;
        if (w_baudLast) begin
          w_nextBaud = '0;
          if (r_stopCnt == LAST_STOP) begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end else begin
            w_nextStop = r_stopCnt + 1'b1;
          end
        end else begin
          w_nextBaud = r_baudCnt + PRESCALE_WIDTH'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Self-checking bench for the UART frame serializer.
// Two builds run side by side (one and two stop bits) sharing the data-side
// inputs; each frame is compared cycle by cycle with a bit list built from the
// UART framing rules.
module tb_uart_tx_frame_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        validA = 1'b0;
  logic        validB = 1'b0;
  logic [7:0]  txData = 8'h00;
  logic        parEnable = 1'b0;
  logic        parType = 1'b0;
  logic [15:0] prescale = 16'd1;

  logic readyA, serialA, busyA, doneA;
  logic readyB, serialB, busyB, doneB;

  logic curSel = 1'b0;
  logic obsSerial, obsReady, obsBusy, obsDone;

  int nChecks = 0;
  int nErrors = 0;

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16), .STOP_BITS(1)) dutA (
    .clk(clk), .reset(reset), .tx_valid(validA), .tx_data(txData), .tx_ready(readyA),
    .parity_enable(parEnable), .parity_type(parType), .prescale(prescale),
    .serial_out(serialA), .busy(busyA), .tx_done(doneA)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16), .STOP_BITS(2)) dutB (
    .clk(clk), .reset(reset), .tx_valid(validB), .tx_data(txData), .tx_ready(readyB),
    .parity_enable(parEnable), .parity_type(parType), .prescale(prescale),
    .serial_out(serialB), .busy(busyB), .tx_done(doneB)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // The checks look at whichever build is currently being exercised.
  assign obsSerial = curSel ? serialB : serialA;
  assign obsReady  = curSel ? readyB  : readyA;
  assign obsBusy   = curSel ? busyB   : busyA;
  assign obsDone   = curSel ? doneB   : doneA;

  // One comparison: counts it, and reports it when it does not hold.
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Line level expected in cycle c (1-based, counted from the accepting edge).
  function automatic logic expBit(input logic [7:0] d, input bit pe, input bit pt,
                                  input int sb, input int p, input int c);
    logic bits[$];
    int ones;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    ones = $countones(d);
    if (pe) bits.push_back(pt ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    return bits[(c - 1) / p];
  endfunction

  task automatic setValid(input bit sel, input logic v);
    if (sel) validB = v;
    else validA = v;
  endtask

  // Idle cycles: line high, ready, not busy, no done pulse.
  task automatic waitIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idleSerial", obsSerial, 1'b1);
      checkOutput("idleDone", obsDone, 1'b0);
      checkOutput("idleBusy", obsBusy, 1'b0);
      checkOutput("idleReady", obsReady, 1'b1);
    end
  endtask

  // Sends one frame from a negedge with the target idle and checks every cycle.
  // keepValid presents the next word straight away (back-to-back); abortCycle
  // > 0 pulls reset low in that cycle and returns with reset still asserted.
  task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit pe,
                               input bit pt, input logic [15:0] presc,
                               input bit keepValid, input logic [7:0] nData,
                               input bit nPe, input bit nPt, input logic [15:0] nPresc,
                               input int abortCycle);
    int p;
    int sb;
    int len;
    curSel = sel;
    p   = (presc == 16'd0) ? 1 : int'(presc);
    sb  = sel ? 2 : 1;
    len = (1 + 8 + (pe ? 1 : 0) + sb) * p;
    checkOutput("readyBeforeAccept", obsReady, 1'b1);
    txData    = data;
    parEnable = pe;
    parType   = pt;
    prescale  = presc;
    setValid(sel, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      checkOutput("frameSerial", obsSerial, expBit(data, pe, pt, sb, p, c));
      checkOutput("frameBusy", obsBusy, 1'b1);
      checkOutput("frameReady", obsReady, 1'b0);
      checkOutput("frameDone", obsDone, 1'b0);
      if (keepValid) begin
        txData    = nData;
        parEnable = nPe;
        parType   = nPt;
        prescale  = nPresc;
      end else begin
        txData    = 8'($urandom);
        parEnable = 1'($urandom);
        parType   = 1'($urandom);
        prescale  = 16'($urandom_range(0, 7));
        setValid(sel, (c > 1) ? logic'($urandom_range(0, 1)) : 1'b0);
      end
      if (c == abortCycle) begin
        setValid(sel, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("abortSerial", obsSerial, 1'b1);
        checkOutput("abortReady", obsReady, 1'b1);
        checkOutput("abortBusy", obsBusy, 1'b0);
        checkOutput("abortDone", obsDone, 1'b0);
        return;
      end
    end
    @(negedge clk);
    checkOutput("doneSerial", obsSerial, 1'b1);
    checkOutput("donePulse", obsDone, 1'b1);
    checkOutput("doneReady", obsReady, 1'b1);
    checkOutput("doneBusy", obsBusy, 1'b0);
    if (!keepValid) setValid(sel, 1'b0);
  endtask

  // Directed steps first, then randomized frames on both builds.
  initial begin
    bit          rSel, rPe, rPt, nSel, nPe, nPt, keep;
    logic [7:0]  rData, nData;
    logic [15:0] rPresc, nPresc;

    repeat (3) @(negedge clk);
    curSel = 1'b0;
    checkOutput("resetSerialA", serialA, 1'b1);
    checkOutput("resetReadyA", readyA, 1'b1);
    checkOutput("resetBusyA", busyA, 1'b0);
    checkOutput("resetDoneA", doneA, 1'b0);
    checkOutput("resetSerialB", serialB, 1'b1);
    checkOutput("resetDoneB", doneB, 1'b0);
    reset = 1'b1;
    waitIdle(2);

    $display("[TB] basic frame 8'hA5, prescale 4, no parity");
    applyStimulus(0, 8'hA5, 0, 0, 16'd4, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(2);

    $display("[TB] parity frames");
    applyStimulus(0, 8'hA5, 1, 0, 16'd4, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);
    applyStimulus(0, 8'hA5, 1, 1, 16'd4, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);
    applyStimulus(0, 8'h07, 1, 0, 16'd4, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);
    applyStimulus(0, 8'h07, 1, 1, 16'd4, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);

    $display("[TB] prescale 0 and 1");
    applyStimulus(0, 8'hFF, 0, 0, 16'd0, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);
    applyStimulus(0, 8'hFF, 0, 0, 16'd1, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);

    $display("[TB] back-to-back frames with mid-frame input changes");
    applyStimulus(0, 8'h3C, 0, 0, 16'd2, 1, 8'hC3, 1, 1, 16'd3, 0);
    applyStimulus(0, 8'hC3, 1, 1, 16'd3, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(2);

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 8'h96, 0, 0, 16'd3, 0, 8'h00, 0, 0, 16'd0, 13);
    @(negedge clk);
    checkOutput("heldResetSerial", obsSerial, 1'b1);
    checkOutput("heldResetDone", obsDone, 1'b0);
    reset = 1'b1;
    waitIdle(3);
    applyStimulus(0, 8'h5A, 1, 0, 16'd2, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(1);

    $display("[TB] two stop bits, 8'h55 even parity, prescale 3");
    applyStimulus(1, 8'h55, 1, 0, 16'd3, 0, 8'h00, 0, 0, 16'd0, 0);
    waitIdle(2);

    $display("[TB] randomized frames");
    rSel   = 1'($urandom);
    rData  = 8'($urandom);
    rPe    = 1'($urandom);
    rPt    = 1'($urandom);
    rPresc = 16'($urandom_range(0, 5));
    for (int i = 0; i < 24; i++) begin
      nSel   = 1'($urandom);
      nData  = 8'($urandom);
      nPe    = 1'($urandom);
      nPt    = 1'($urandom);
      nPresc = 16'($urandom_range(0, 5));
      keep   = (i < 23) && (nSel == rSel) && ($urandom_range(0, 1) == 1);
      applyStimulus(rSel, rData, rPe, rPt, rPresc, keep, nData, nPe, nPt, nPresc, 0);
      if (!keep) waitIdle($urandom_range(1, 3));
      rSel   = nSel;
      rData  = nData;
      rPe    = nPe;
      rPt    = nPt;
      rPresc = nPresc;
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
